// File: rtl/alu_issue_stage.sv
// Single-issue ALU front end: decodes an instruction, reads operands from a
// 4x8 register file, drives an external ALU and writes the result back.
module alu_issue_stage #(
  parameter logic [7:0] OP_SUM = 8'h01,
  parameter logic [7:0] OP_SUB = 8'h02,
  parameter logic [7:0] OP_INC = 8'h03,
  parameter logic [7:0] OP_DEC = 8'h04,
  parameter logic [7:0] OP_LDI = 8'h10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        instr_valid,
  output logic        instr_ready,
  input  logic [23:0] instr,
  output logic [7:0]  alu_a,
  output logic [7:0]  alu_b,
  output logic [7:0]  alu_op,
  input  logic [7:0]  alu_result,
  output logic        wb_valid,
  output logic [1:0]  wb_addr,
  output logic [7:0]  wb_data,
  output logic        err,
  input  logic [1:0]  dbg_addr,
  output logic [7:0]  dbg_data
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_WB   = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    CLS_ALU = 2'd0,
    CLS_LDI = 2'd1,
    CLS_BAD = 2'd2
  } op_class_t;

  state_t     state_r;
  logic [7:0] regs_r [4];
  logic [7:0] result_r;
  logic [1:0] rd_r;
  logic       ready_r;
  logic [7:0] alu_a_r;
  logic [7:0] alu_b_r;
  logic [7:0] alu_op_r;
  logic       wb_valid_r;
  logic [1:0] wb_addr_r;
  logic [7:0] wb_data_r;
  logic       err_r;

  logic [7:0] op_s;
  logic [1:0] rd_s;
  logic [1:0] rs_a_s;
  logic [1:0] rs_b_s;
  logic [7:0] imm_s;
  logic       accept_s;
  op_class_t  op_class_s;
  logic       unused_bits_s;

  assign op_s          = instr[23:16];
  assign rd_s          = instr[15:14];
  assign rs_a_s        = instr[13:12];
  assign rs_b_s        = instr[11:10];
  assign imm_s         = instr[7:0];
  assign unused_bits_s = ^instr[9:8];
  assign accept_s      = instr_valid && ready_r;

  // Classify the offered opcode: ALU-issued, local load-immediate, or illegal.
  always_comb begin
    op_class_s = CLS_BAD;
    case (op_s)
      OP_SUM, OP_SUB, OP_INC, OP_DEC: op_class_s = CLS_ALU;
      OP_LDI:                         op_class_s = CLS_LDI;
      default:                        op_class_s = CLS_BAD;
    endcase
  end

  // Issue FSM with register file and all registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r    <= ST_IDLE;
      ready_r    <= 1'b1;
      result_r   <= 8'h00;
      rd_r       <= 2'd0;
      alu_a_r    <= 8'h00;
      alu_b_r    <= 8'h00;
      alu_op_r   <= 8'h00;
      wb_valid_r <= 1'b0;
      wb_addr_r  <= 2'd0;
      wb_data_r  <= 8'h00;
      err_r      <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        regs_r[i] <= 8'h00;
      end
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (accept_s) begin
            case (op_class_s)
              CLS_ALU: begin
                alu_a_r  <= regs_r[rs_a_s];
                alu_b_r  <= regs_r[rs_b_s];
                alu_op_r <= op_s;
                rd_r     <= rd_s;
                ready_r  <= 1'b0;
                state_r  <= ST_EXEC;
              end
              CLS_LDI: begin
                // Skips EXEC: the immediate is the result, ALU operands untouched.
                result_r   <= imm_s;
                rd_r       <= rd_s;
                wb_valid_r <= 1'b1;
                wb_addr_r  <= rd_s;
                wb_data_r  <= imm_s;
                ready_r    <= 1'b0;
                state_r    <= ST_WB;
              end
              default: begin
                err_r   <= 1'b1;
                state_r <= ST_IDLE;
              end
            endcase
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_EXEC: begin
          result_r   <= alu_result;
          wb_valid_r <= 1'b1;
          wb_addr_r  <= rd_r;
          wb_data_r  <= alu_result;
          state_r    <= ST_WB;
        end
        ST_WB: begin
          regs_r[rd_r] <= result_r;
          wb_valid_r   <= 1'b0;
          ready_r      <= 1'b1;
          state_r      <= ST_IDLE;
        end
        default: begin
          wb_valid_r <= 1'b0;
          ready_r    <= 1'b1;
          state_r    <= ST_IDLE;
        end
      endcase
    end
  end

  assign instr_ready = ready_r;
  assign alu_a       = alu_a_r;
  assign alu_b       = alu_b_r;
  assign alu_op      = alu_op_r;
  assign wb_valid    = wb_valid_r;
  assign wb_addr     = wb_addr_r;
  assign wb_data     = wb_data_r;
  assign err         = err_r;
  assign dbg_data    = regs_r[dbg_addr];

endmodule
